// File: rtl/dmem_pkg.sv
// Shared types and lane helpers for the MEM-stage data memory.
// Optional access-fault checking is enabled with DMEM_ALIGN_EXC_EN.
package dmem_pkg;

    localparam logic [1:0] SZ_WORD = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_BYTE = 2'd2;

    typedef enum logic [1:0] {
        ST_INIT,
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } state_t;

    // Merge low-aligned store data into the selected lane(s) of a word.
    function automatic logic [31:0] lane_merge(
        input logic [31:0] old,
        input logic [31:0] wd,
        input logic [1:0]  size,
        input logic [1:0]  lo
    );
        logic [31:0] r;
        r = old;
        case (size)
            SZ_HALF: begin
                if (lo[1]) r[31:16] = wd[15:0];
                else       r[15:0]  = wd[15:0];
            end
            SZ_BYTE: r[{lo, 3'b000} +: 8] = wd[7:0];
            default: r = wd;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] extend(
        input logic [31:0] word,
        input logic [1:0]  size,
        input logic        uns,
        input logic [1:0]  lo
    );
        logic [31:0] r;
        logic [15:0] h;
        logic [7:0]  b;
        h = lo[1] ? word[31:16] : word[15:0];
        b = word[{lo, 3'b000} +: 8];
        case (size)
            SZ_HALF: r = {{16{~uns & h[15]}}, h};
            SZ_BYTE: r = {{24{~uns & b[7]}}, b};
            default: r = word;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/dmem_ctrl_lane_ext.sv
// Load lane select and sign/zero extension on the response path.
// Purely combinational; wraps the package extend helper.
module dmem_lane_ext
    import dmem_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  size,
    input  logic        uns,
    input  logic [1:0]  lo,
    output logic [31:0] data
);

    assign data = extend(word, size, uns, lo);

endmodule

// File: rtl/dmem_ctrl.sv
// MEM-stage data memory: valid/ready request, fixed-latency response, reset sweep.
// Define DMEM_ALIGN_EXC_EN to fault misaligned and out-of-range accesses.
module dmem_ctrl
    import dmem_pkg::*;
#(
    parameter int          DEPTH_LOG2 = 11,
    parameter int          LATENCY    = 1,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_exc
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [2:0] LAT_INIT = (LATENCY > 1) ? 3'(LATENCY - 2) : 3'd0;

    logic [31:0] mem [DEPTH];

    state_t state_q, state_d;
    logic [DEPTH_LOG2-1:0] sweep_q;
    logic [2:0]            lat_q;

    logic                  accept;
    logic                  fault;
    logic [31:0]           off;
    logic [DEPTH_LOG2-1:0] idx;

    logic [31:0] rd_q;
    logic [1:0]  size_q;
    logic [1:0]  lo_q;
    logic        uns_q;
    logic        we_q;
    logic        exc_q;
    logic [31:0] ext;

    assign off    = req_addr - BASE_ADDR;
    assign idx    = off[DEPTH_LOG2+1:2];
    assign accept = req_valid & req_ready;

`ifdef DMEM_ALIGN_EXC_EN
    logic in_range;
    logic is_word;
    assign in_range = (off >> (DEPTH_LOG2 + 2)) == 32'd0;
    assign is_word  = (req_size != SZ_HALF) && (req_size != SZ_BYTE);
    assign fault    = !in_range
                    || ((req_size == SZ_HALF) && req_addr[0])
                    || (is_word && (req_addr[1:0] != 2'b00));
`else
    logic unused_off;
    assign unused_off = ^off;
    assign fault      = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        req_ready = 1'b0;
        unique case (state_q)
            ST_INIT: begin
                if (&sweep_q) state_d = ST_IDLE;
            end
            ST_IDLE, ST_RESP: begin
                req_ready = 1'b1;
                if (req_valid)
                    state_d = (LATENCY == 1) ? ST_RESP : ST_WAIT;
                else
                    state_d = ST_IDLE;
            end
            ST_WAIT: begin
                if (lat_q == 3'd0) state_d = ST_RESP;
            end
            default: state_d = ST_INIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_INIT;
            sweep_q <= '0;
            lat_q   <= '0;
            rd_q    <= '0;
            size_q  <= SZ_WORD;
            lo_q    <= 2'b00;
            uns_q   <= 1'b0;
            we_q    <= 1'b0;
            exc_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_INIT) sweep_q <= sweep_q + 1'b1;
            if (accept) begin
                lat_q  <= LAT_INIT;
                rd_q   <= mem[idx];
                size_q <= req_size;
                lo_q   <= req_addr[1:0];
                uns_q  <= req_unsigned;
                we_q   <= req_we;
                exc_q  <= fault;
            end else if (state_q == ST_WAIT) begin
                lat_q <= lat_q - 1'b1;
            end
        end
    end

    // Single write port shared by the reset sweep and committed stores.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (state_q == ST_INIT)
                mem[sweep_q] <= '0;
            else if (accept && req_we && !fault)
                mem[idx] <= lane_merge(mem[idx], req_wdata,
                                       req_size, req_addr[1:0]);
        end
    end

    dmem_lane_ext u_ext (
        .word (rd_q),
        .size (size_q),
        .uns  (uns_q),
        .lo   (lo_q),
        .data (ext)
    );

    assign rsp_valid = (state_q == ST_RESP);
    assign rsp_rdata = (rsp_valid && !we_q && !exc_q) ? ext : 32'd0;

`ifdef DMEM_ALIGN_EXC_EN
    assign rsp_exc = rsp_valid & exc_q;
`else
    assign rsp_exc = 1'b0;
`endif

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed plus randomized checks of dmem_ctrl against a byte-array model.
// Instance a runs at LATENCY=3, instance b at LATENCY=1 for back-to-back traffic.
module tb_dmem_ctrl;

    localparam int LAT = 3;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic        a_valid, a_ready, a_we, a_uns, a_rv, a_exc;
    logic [1:0]  a_size;
    logic [31:0] a_addr, a_wd, a_rd;
    logic        b_valid, b_ready, b_we, b_uns, b_rv, b_exc;
    logic [1:0]  b_size;
    logic [31:0] b_addr, b_wd, b_rd;

    dmem_ctrl #(.DEPTH_LOG2(4), .LATENCY(LAT), .BASE_ADDR(32'h0)) u_a (
        .clk(clk), .reset(reset),
        .req_valid(a_valid), .req_ready(a_ready), .req_we(a_we),
        .req_size(a_size), .req_unsigned(a_uns), .req_addr(a_addr),
        .req_wdata(a_wd), .rsp_valid(a_rv), .rsp_rdata(a_rd), .rsp_exc(a_exc)
    );

    dmem_ctrl #(.DEPTH_LOG2(4), .LATENCY(1), .BASE_ADDR(32'h0)) u_b (
        .clk(clk), .reset(reset),
        .req_valid(b_valid), .req_ready(b_ready), .req_we(b_we),
        .req_size(b_size), .req_unsigned(b_uns), .req_addr(b_addr),
        .req_wdata(b_wd), .rsp_valid(b_rv), .rsp_rdata(b_rd), .rsp_exc(b_exc)
    );

    int total = 0;
    int bad = 0;
    logic [7:0] mb [2][64];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic clear_model();
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < 64; i++) mb[k][i] = 8'h00;
    endtask

    // Byte-addressed view of a 16-word memory; returns load data, updates on store.
    function automatic logic [31:0] mdl(input int k, input logic we, input logic [1:0] sz,
                                        input logic uns, input logic [31:0] a,
                                        input logic [31:0] wd, output logic fx);
        int nb, b;
        logic [31:0] v;
        nb = (sz == 2'd1) ? 2 : (sz == 2'd2) ? 1 : 4;
        b = int'(a % 32'd64);
        b = b - (b % nb);
        fx = 1'b0;
`ifdef DMEM_ALIGN_EXC_EN
        fx = (a >= 32'd64) || (int'(a % 32'(nb)) != 0);
`endif
        v = 32'd0;
        for (int i = 0; i < nb; i++) v |= 32'(mb[k][b+i]) << (8 * i);
        if (!uns && nb < 4 && v[8*nb-1]) v |= 32'hFFFF_FFFF << (8 * nb);
        if (we && !fx)
            for (int i = 0; i < nb; i++) mb[k][b+i] = 8'(wd >> (8 * i));
        return (we || fx) ? 32'd0 : v;
    endfunction

    task automatic a_op(input string tag, input logic we, input logic [1:0] sz,
                        input logic uns, input logic [31:0] ad, input logic [31:0] wd,
                        input logic use_c, input logic [31:0] cexp);
        logic [31:0] e;
        logic fx;
        int n;
        e = mdl(0, we, sz, uns, ad, wd, fx);
        if (use_c) e = cexp;
        @(negedge clk);
        a_valid = 1'b1; a_we = we; a_size = sz; a_uns = uns; a_addr = ad; a_wd = wd;
        n = 0;
        while (a_ready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        chk({tag, ":ready"}, 32'(a_ready), 32'd1);
        @(posedge clk); #1;
        a_valid = 1'b0;
        n = 0;
        while (a_rv !== 1'b1 && n < 20) begin
            chk({tag, ":wait_ready"}, 32'(a_ready), 32'd0);
            @(posedge clk); #1;
            n++;
        end
        chk({tag, ":latency"}, 32'(n), 32'(LAT - 1));
        chk({tag, ":rdata"}, a_rd, e);
        chk({tag, ":exc"}, 32'(a_exc), 32'(fx));
    endtask

    task automatic release_reset(input string tag);
        int n;
        @(negedge clk);
        reset = 1'b0;
        n = 0;
        while (a_ready !== 1'b1 && n < 100) begin @(negedge clk); n++; end
        chk({tag, ":init_cycles"}, 32'(n), 32'd16);
        chk({tag, ":b_ready"}, 32'(b_ready), 32'd1);
    endtask

    initial begin
        logic [1:0]  sz;
        logic [31:0] ad, wd, e;
        logic        we, uns, fx;

        a_valid = 0; a_we = 0; a_size = 0; a_uns = 0; a_addr = 0; a_wd = 0;
        b_valid = 0; b_we = 0; b_size = 0; b_uns = 0; b_addr = 0; b_wd = 0;
        clear_model();

        repeat (3) begin
            @(posedge clk); #1;
            chk("rst_ready", 32'(a_ready), 32'd0);
            chk("rst_rv", 32'(a_rv), 32'd0);
            chk("rst_rdata", a_rd, 32'd0);
            chk("rst_exc", 32'(a_exc), 32'd0);
        end
        release_reset("boot");
        a_op("lw0", 0, 2'd0, 0, 32'h00, 0, 1, 32'h0000_0000);

        a_op("sw10", 1, 2'd0, 0, 32'h10, 32'h1234_5678, 1, 32'h0);
        a_op("lb11", 0, 2'd2, 0, 32'h11, 0, 1, 32'h0000_0056);
        a_op("lbu13", 0, 2'd2, 1, 32'h13, 0, 1, 32'h0000_0012);
        a_op("lh12", 0, 2'd1, 0, 32'h12, 0, 1, 32'h0000_1234);
        a_op("lw10", 0, 2'd0, 0, 32'h10, 0, 1, 32'h1234_5678);

        a_op("sb20", 1, 2'd2, 0, 32'h20, 32'h80, 1, 32'h0);
        a_op("lb20", 0, 2'd2, 0, 32'h20, 0, 1, 32'hFFFF_FF80);
        a_op("lbu20", 0, 2'd2, 1, 32'h20, 0, 1, 32'h0000_0080);
        a_op("sh22", 1, 2'd1, 0, 32'h22, 32'hBEEF, 1, 32'h0);
        a_op("lw20", 0, 2'd0, 0, 32'h20, 0, 1, 32'hBEEF_0080);

        a_op("sh21", 1, 2'd1, 0, 32'h21, 32'h1111, 0, 32'h0);
`ifdef DMEM_ALIGN_EXC_EN
        a_op("lw20b", 0, 2'd0, 0, 32'h20, 0, 1, 32'hBEEF_0080);
`else
        a_op("lw20b", 0, 2'd0, 0, 32'h20, 0, 1, 32'hBEEF_1111);
`endif
        a_op("sw4c", 1, 2'd0, 0, 32'h4C, 32'hCAFE_F00D, 0, 32'h0);
        a_op("lw0c", 0, 2'd0, 0, 32'h0C, 0, 0, 32'h0);

        for (int i = 0; i < 20; i++) begin
            sz = 2'($urandom_range(0, 3));
            ad = 32'($urandom_range(0, 63));
            if (sz == 2'd1) ad = ad & ~32'd1;
            if (sz == 2'd0 || sz == 2'd3) ad = ad & ~32'd3;
            a_op("rand_a", 1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)),
                 ad, $urandom, 0, 32'h0);
        end

        for (int i = 0; i < 24; i++) begin
            sz  = 2'($urandom_range(0, 3));
            ad  = 32'($urandom_range(0, 63));
            if (sz == 2'd1) ad = ad & ~32'd1;
            if (sz == 2'd0 || sz == 2'd3) ad = ad & ~32'd3;
            we  = (i < 8) ? 1'b1 : 1'($urandom_range(0, 1));
            uns = 1'($urandom_range(0, 1));
            wd  = $urandom;
            e   = mdl(1, we, sz, uns, ad, wd, fx);
            @(negedge clk);
            b_valid = 1'b1; b_we = we; b_size = sz; b_uns = uns; b_addr = ad; b_wd = wd;
            chk("b2b_ready", 32'(b_ready), 32'd1);
            @(posedge clk); #1;
            chk("b2b_rv", 32'(b_rv), 32'd1);
            chk("b2b_rdata", b_rd, e);
            chk("b2b_exc", 32'(b_exc), 32'(fx));
        end
        @(negedge clk);
        b_valid = 1'b0;
        @(posedge clk); #1;
        chk("b_idle_rv", 32'(b_rv), 32'd0);
        chk("b_idle_rdata", b_rd, 32'd0);

        a_op("sw10r", 1, 2'd0, 0, 32'h10, 32'hA5A5_A5A5, 0, 32'h0);
        @(negedge clk);
        a_valid = 1'b1; a_we = 0; a_size = 2'd0; a_uns = 0; a_addr = 32'h10;
        @(posedge clk); #1;
        a_valid = 1'b0;
        chk("midwait_rv", 32'(a_rv), 32'd0);
        reset = 1'b1;
        repeat (4) begin
            @(posedge clk); #1;
            chk("rst_wait_rv", 32'(a_rv), 32'd0);
        end
        clear_model();
        release_reset("reinit");
        a_op("lw10_clr", 0, 2'd0, 0, 32'h10, 0, 1, 32'h0000_0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
